// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
// The master drives operands and out_ready; the slave (the adder) returns status and result.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum, carry, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum, carry, busy
  );
endinterface

// File: rtl/halfadder.sv
// One-bit half adder cell; combinational only.
module halfadder (
  input  logic a_i,
  input  logic b_i,
  output logic sum_o,
  output logic carry_o
);
  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one bit per clock, LSB first, registered carry.
// Operands in and result out each use a valid/ready handshake; ready/valid decode from state only.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave sa
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ha1_sum, ha1_carry, ha2_sum, ha2_carry;
  logic bit_sum, carry_next;

  halfadder u_ha1 (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .sum_o   (ha1_sum),
    .carry_o (ha1_carry)
  );

  halfadder u_ha2 (
    .a_i     (ha1_sum),
    .b_i     (c_q),
    .sum_o   (ha2_sum),
    .carry_o (ha2_carry)
  );

  assign bit_sum    = ha2_sum;
  assign carry_next = ha1_carry | ha2_carry;

  always_comb begin
    // NOTE: every next-state value defaults to its register so no path through the case infers a latch.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (sa.in_valid) begin
          a_sh_d  = sa.a;
          b_sh_d  = sa.b;
          s_sh_d  = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // New bit enters at the MSB so the first computed bit ends up at bit 0.
        s_sh_d            = s_sh_q >> 1;
        s_sh_d[WIDTH-1]   = bit_sum;
        c_d   = carry_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (sa.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the sum register is reset too, because sum is driven straight from it and must read 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sa.in_ready  = (state_q == ST_IDLE);
  assign sa.busy      = (state_q == ST_RUN);
  assign sa.out_valid = (state_q == ST_DONE);
  assign sa.sum       = s_sh_q;
  assign sa.carry     = c_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder: expected a+b pushed on accept, popped by a monitor on each new result.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(WIDTH)) sa ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sa    (sa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: each rising out_valid is one new result.
  initial begin : monitor
    logic prev_valid;
    logic [WIDTH:0] e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (sa.out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 64'(sa.out_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("result", 64'({sa.carry, sa.sum}), 64'(e));
          end
        end
        prev_valid = sa.out_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Issue one operation; stall>0 holds out_ready low that many cycles in DONE.
  // junk=1 pulses in_valid with other operands during RUN.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int stall, input bit junk);
    int n;
    int lat;
    int busy_n;
    logic [WIDTH:0] model;
    model = {1'b0, a} + {1'b0, b};
    n = 0;
    while (!sa.in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) check("in_ready_timeout", 64'(sa.in_ready), 64'd1);
    sa.out_ready = (stall == 0);
    sa.a = a;
    sa.b = b;
    sa.in_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(model);
    #1;
    sa.in_valid = 1'b0;
    lat = -1;
    busy_n = sa.busy ? 1 : 0;
    for (int k = 1; k <= WIDTH + 3; k++) begin
      @(posedge clk); #1;
      if (sa.in_valid) begin
        sa.in_valid = 1'b0;
        sa.a = a;
        sa.b = b;
      end
      if (sa.busy) busy_n++;
      if (sa.out_valid && lat < 0) lat = k;
      if (junk && k == 3) begin
        sa.a = 8'h33;
        sa.b = 8'h11;
        sa.in_valid = 1'b1;
      end
    end
    check("latency", 64'(lat), 64'(WIDTH));
    check("busy_cycles", 64'(busy_n), 64'(WIDTH));
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check("stall_valid", 64'(sa.out_valid), 64'd1);
        check("stall_in_ready", 64'(sa.in_ready), 64'd0);
        check("stall_result", 64'({sa.carry, sa.sum}), 64'(model));
      end
      sa.out_ready = 1'b1;
      @(posedge clk); #1;
      check("release_in_ready", 64'(sa.in_ready), 64'd1);
      check("release_valid", 64'(sa.out_valid), 64'd0);
    end
  endtask

  initial begin : stimulus
    logic [WIDTH-1:0] ra, rb;
    int n;
    sa.in_valid  = 1'b0;
    sa.a         = '0;
    sa.b         = '0;
    sa.out_ready = 1'b1;
    rst_n        = 1'b0;
    #1;
    check("reset_in_ready", 64'(sa.in_ready), 64'd1);
    check("reset_out_valid", 64'(sa.out_valid), 64'd0);
    check("reset_busy", 64'(sa.busy), 64'd0);
    check("reset_sum_carry", 64'({sa.carry, sa.sum}), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'h00, 8'h00, 0, 1'b0);
    run_op(8'hFF, 8'h01, 0, 1'b0);
    run_op(8'hA5, 8'h5A, 0, 1'b0);
    run_op(8'h80, 8'h80, 0, 1'b0);
    run_op(8'hC3, 8'h7E, 5, 1'b0);
    run_op(8'h12, 8'h34, 0, 1'b0);
    run_op(8'h0F, 8'h01, 0, 1'b1);

    // Reset in the middle of RUN: nothing is pushed, the operation must vanish.
    sa.out_ready = 1'b1;
    sa.a = 8'hEE;
    sa.b = 8'hDD;
    sa.in_valid = 1'b1;
    @(posedge clk); #1;
    sa.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrun_in_ready", 64'(sa.in_ready), 64'd1);
    check("midrun_out_valid", 64'(sa.out_valid), 64'd0);
    check("midrun_busy", 64'(sa.busy), 64'd0);
    check("midrun_sum_carry", 64'({sa.carry, sa.sum}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'h7F, 8'h01, 0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op(ra, rb, (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0), 1'b0);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); n++;
    end
    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around the team's `halfadder` cell. It accepts two parallel operands through a valid/ready handshake and adds them one bit per clock, LSB first, using a single registered carry. It returns the WIDTH-bit sum and carry-out through a valid/ready handshake. It is the sequential consumer of `halfadder` and the area-cheap alternative to a ripple-carry adder in datapaths that tolerate multi-cycle latency.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset; deassertion is synchronous to `clk` externally.
- `in_valid`  in  1: operands `a`/`b` are valid.
- `in_ready`  out  1: block can accept operands.
- `a`  in  WIDTH: operand A, unsigned.
- `b`  in  WIDTH: operand B, unsigned.
- `out_valid`  out  1: `sum`/`carry` hold a completed result.
- `out_ready`  in  1: consumer takes the result.
- `sum`  out  WIDTH: a+b modulo 2^WIDTH.
- `carry`  out  1: carry-out of bit WIDTH-1.
- `busy`  out  1: high in RUN state.

## Operation
- Datapath:
  - Operand shift registers `a_sh` and `b_sh` (WIDTH bits each).
  - Sum shift register `s_sh` (WIDTH bits).
  - Carry flop `c`.
  - Bit counter `cnt`, $clog2(WIDTH+1) bits.
- Full adder cell: two `halfadder` instances plus an OR.
  - HA1 takes `a_sh[0]` and `b_sh[0]`.
  - HA2 takes HA1.sum and `c`.
  - Bit sum is HA2.sum; carry-next is HA1.carry | HA2.carry.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: load `a_sh`←`a`, `b_sh`←`b`, `c`←0, `cnt`←0, `s_sh`←0, then go to RUN.
  - `in_valid`=0: stay in IDLE with all state held.
- RUN, every cycle:
  - `a_sh`, `b_sh` shift right by 1; zero-fill the MSB.
  - `s_sh` ← {bit sum, `s_sh`[WIDTH-1:1]}, so the first bit computed ends at bit 0.
  - `c` ← carry-next; `cnt` ← `cnt`+1.
  - When `cnt`==WIDTH-1, the update is the final bit and the next state is DONE.
- DONE:
  - `out_valid`=1; `sum`=`s_sh`, `carry`=`c`, both stable.
  - On `out_ready`=1, go to IDLE.
  - `out_ready`=0: stay in DONE indefinitely, outputs frozen.
- `in_ready`=0 in RUN and DONE. `in_valid`/`a`/`b` are ignored there and no operand is latched.
- `sum`/`carry` are driven directly from `s_sh`/`c`. They are meaningful only while `out_valid`=1.
- Width rules:
  - Unsigned addition.
  - Overflow appears only on `carry`; no saturation.
  - WIDTH=1 takes a single RUN cycle.

## Timing
- Reset (`rst_n`=0, asynchronous, any state including mid-RUN):
  - State ← IDLE.
  - `in_ready`=1, `out_valid`=0, `busy`=0.
  - `sum`=0, `carry`=0.
  - `cnt`, `a_sh`, `b_sh`, `c` ← 0.
  - Any in-flight operation is discarded; no partial result is ever presented.
- Latency: with acceptance at rising edge E, `out_valid` is high from edge E+WIDTH onward.
- `busy` is high for exactly WIDTH cycles.
- Result handshake: the result is consumed at the first edge where `out_valid & out_ready`=1. `in_ready` rises at that same edge.
- Minimum initiation interval: WIDTH+2 cycles.
  - There is one mandatory IDLE cycle.
  - Accept and complete are never in the same cycle.
- `out_ready` held high before DONE has no effect until DONE is entered.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. Both ready/valid outputs decode purely from state.

## Test plan
- Basic add, WIDTH=8: reset, then accept `a`=8'h00, `b`=8'h00.
  - Required: `out_valid` rises 8 cycles after accept, with `sum`=8'h00 and `carry`=0.
  - Also: `busy` is high exactly 8 cycles.
- Full carry ripple: `a`=8'hFF, `b`=8'h01 → `sum`=8'h00, `carry`=1.
- No carries: `a`=8'hA5, `b`=8'h5A → `sum`=8'hFF, `carry`=0.
  - Then `a`=8'h80, `b`=8'h80 → `sum`=8'h00, `carry`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE.
  - Required: `out_valid`, `sum` and `carry` stay stable and `in_ready`=0.
  - Raise `out_ready`: `in_ready`=1 at the next edge.
  - Next accept: result follows WIDTH cycles later.
- Ignored input: pulse `in_valid` with `a`=8'h33, `b`=8'h11 during RUN of a 8'h0F+8'h01 operation.
  - Required: `sum`=8'h10, `carry`=0; the second operand pair is never latched.
- Reset mid-operation: assert `rst_n`=0 at RUN cycle 4, asynchronously between clock edges.
  - Required: `in_ready`=1, `out_valid`=0, `sum`=0 and `carry`=0 immediately, before the next edge.
  - After release, `a`=8'h7F, `b`=8'h01 → `sum`=8'h80, `carry`=0.
